// File: rtl/instr_loader_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | instr_loader_if : byte stream in, instruction-memory writes out  |
// | Revision 1.0                                                      |
// +------------------------------------------------------------------+
interface instr_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;

  // master: the loader, which drives the memory write port and accepts bytes
  modport master (
    input  rx_data, rx_valid,
    output rx_ready, mem_addr, mem_wdata, mem_we
  );

  modport slave (
    output rx_data, rx_valid,
    input  rx_ready, mem_addr, mem_wdata, mem_we
  );
endinterface
`default_nettype wire

// File: rtl/instr_loader.sv
`default_nettype none
// +------------------------------------------------------------------+
// | instr_loader : loads a checksummed big-endian word stream into   |
// | instruction memory while holding the CPU in reset. Revision 1.0   |
// +------------------------------------------------------------------+
module instr_loader #(
  parameter int AW = 9
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  instr_loader_if.master bus,
  output logic           busy,
  output logic           done,
  output logic           error,
  output logic           cpu_reset
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_LEN_HI = 4'd1;
  localparam logic [3:0] S_LEN_LO = 4'd2;
  localparam logic [3:0] S_DAT_HI = 4'd3;
  localparam logic [3:0] S_DAT_LO = 4'd4;
  localparam logic [3:0] S_SUM_HI = 4'd5;
  localparam logic [3:0] S_SUM_LO = 4'd6;
  localparam logic [3:0] S_DONE   = 4'd7;
  localparam logic [3:0] S_ERR    = 4'd8;

  localparam logic [16:0] DEPTH = 17'(1) << AW;

  logic [3:0]    state_q, state_d;
  logic [7:0]    hi_q, hi_d;
  logic [15:0]   n_q, n_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [15:0]   csum_q, csum_d;
  logic          we_q, we_d;
  logic [15:0]   wdata_q, wdata_d;
  logic [15:0]   maddr_q, maddr_d;
  logic          done_q, done_d;
  logic          error_q, error_d;

  logic          rx_ready;
  logic          xfer;
  logic [15:0]   word;

  assign rx_ready = (state_q >= S_LEN_HI) && (state_q <= S_SUM_LO);
  assign xfer     = bus.rx_valid && rx_ready;
  assign word     = {hi_q, bus.rx_data};

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    csum_d  = csum_q;
    we_d    = 1'b0;
    wdata_d = wdata_q;
    maddr_d = maddr_q;
    done_d  = done_q;
    error_d = error_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_LEN_HI;
          done_d  = 1'b0;
          error_d = 1'b0;
          cnt_d   = 16'd0;
          addr_d  = '0;
          csum_d  = 16'd0;
        end
      end
      S_LEN_HI, S_DAT_HI, S_SUM_HI: begin
        if (xfer) begin
          hi_d    = bus.rx_data;
          state_d = state_q + 4'd1;
        end
      end
      S_LEN_LO: begin
        if (xfer) begin
          n_d = word;
          if ((word == 16'd0) || ({1'b0, word} > DEPTH)) begin
            state_d = S_ERR;
            error_d = 1'b1;
          end else begin
            state_d = S_DAT_HI;
          end
        end
      end
      S_DAT_LO: begin
        if (xfer) begin
          // the write lands next cycle, overlapping acceptance of the next byte
          we_d    = 1'b1;
          wdata_d = word;
          maddr_d = 16'(addr_q);
          addr_d  = addr_q + AW'(1);
          csum_d  = csum_q + word;
          cnt_d   = cnt_q + 16'd1;
          state_d = (cnt_d == n_q) ? S_SUM_HI : S_DAT_HI;
        end
      end
      S_SUM_LO: begin
        if (xfer) begin
          if (word == csum_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_ERR;
            error_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      hi_q    <= 8'd0;
      n_q     <= 16'd0;
      cnt_q   <= 16'd0;
      addr_q  <= '0;
      csum_q  <= 16'd0;
      we_q    <= 1'b0;
      wdata_q <= 16'd0;
      maddr_q <= 16'd0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      csum_q  <= csum_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      maddr_q <= maddr_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  assign bus.rx_ready  = rx_ready;
  assign bus.mem_we    = we_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_addr  = maddr_q;
  assign busy          = rx_ready || we_q;
  assign cpu_reset     = busy;
  assign done          = done_q;
  assign error         = error_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_loader.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_instr_loader : vector table, hand sequences and random streams |
// | against a stream-level reference model. Revision 1.0              |
// +------------------------------------------------------------------+
module tb_instr_loader;
  localparam int AW    = 9;
  localparam int DEPTH = 1 << AW;

  typedef logic [7:0] u8_t;
  typedef struct {
    logic [95:0] bytes;
    int          len;
    int          idle;
    logic        exp_done;
    logic        exp_err;
    int          exp_nw;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic busy, done, error, cpu_reset;

  instr_loader_if bus ();

  instr_loader #(.AW(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bus       (bus.master),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .cpu_reset (cpu_reset)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  u8_t         stim_q[$];
  logic [31:0] wr_q[$];
  logic [31:0] exp_wr_q[$];
  logic        exp_done, exp_err;

  always @(negedge clk) begin
    if (bus.mem_we) wr_q.push_back({bus.mem_addr, bus.mem_wdata});
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: parse the stream by its format rules, not by state.
  task automatic model_stream();
    int n;
    int sum;
    logic [15:0] w, chk;
    exp_wr_q.delete();
    exp_done = 1'b0;
    exp_err  = 1'b0;
    sum = 0;
    n = int'(stim_q[0]) * 256 + int'(stim_q[1]);
    if (n == 0 || n > DEPTH) begin
      exp_err = 1'b1;
      return;
    end
    for (int k = 0; k < n; k++) begin
      w = {stim_q[2+2*k], stim_q[3+2*k]};
      exp_wr_q.push_back({16'(k), w});
      sum = (sum + int'(w)) % 65536;
    end
    chk = {stim_q[2+2*n], stim_q[3+2*n]};
    exp_done = (int'(chk) == sum);
    exp_err  = !exp_done;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rx_ready"}, 32'(bus.rx_ready), 0);
    check({tag, "_mem_we"},   32'(bus.mem_we), 0);
    check({tag, "_busy"},     32'(busy), 0);
    check({tag, "_done"},     32'(done), 0);
    check({tag, "_error"},    32'(error), 0);
    check({tag, "_cpu_rst"},  32'(cpu_reset), 0);
    check({tag, "_addr"},     32'(bus.mem_addr), 0);
    check({tag, "_wdata"},    32'(bus.mem_wdata), 0);
  endtask

  task automatic send_bytes(input int from, input int upto, input int idle_pct,
                            input bit startp, input int budget);
    int i = from;
    int cyc = 0;
    int r;
    while (i < upto && cyc < budget) begin
      @(negedge clk);
      cyc++;
      r = int'($urandom_range(99));
      bus.rx_valid = (r >= idle_pct);
      bus.rx_data  = bus.rx_valid ? stim_q[i] : u8_t'($urandom);
      start        = startp && ($urandom_range(7) == 0);
      if (bus.rx_valid && bus.rx_ready) i++;
    end
    @(negedge clk);
    bus.rx_valid = 1'b0;
    start = 1'b0;
    check("bytes_consumed", 32'(i), 32'(upto));
  endtask

  task automatic wait_idle(input int budget);
    int cyc = 0;
    while (busy && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    check("idle_timeout", 32'(busy), 0);
  endtask

  task automatic compare_writes();
    check("nwrites", 32'(wr_q.size()), 32'(exp_wr_q.size()));
    for (int k = 0; k < wr_q.size() && k < exp_wr_q.size(); k++)
      check("write_addr_data", wr_q[k], exp_wr_q[k]);
  endtask

  task automatic run_stream(input int idle_pct, input bit startp, input int budget);
    model_stream();
    wr_q.delete();
    pulse_start();
    check("busy_after_start", 32'(busy), 1);
    check("flags_cleared", {30'd0, done, error}, 0);
    send_bytes(0, stim_q.size(), idle_pct, startp, budget);
    wait_idle(budget);
    check("done", 32'(done), 32'(exp_done));
    check("error", 32'(error), 32'(exp_err));
    check("cpu_reset_after", 32'(cpu_reset), 0);
    compare_writes();
  endtask

  task automatic load_good();
    stim_q.delete();
    stim_q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hBE, 8'h01};
  endtask

  vec_t vt[8];

  initial begin
    int n;
    int sum;
    logic [15:0] w;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;

    vt[0] = '{96'h0002_1234_ABCD_BE01_0000_0000, 8, 0,  1'b1, 1'b0, 2};
    vt[1] = '{96'h0001_0007_0008_0000_0000_0000, 6, 0,  1'b0, 1'b1, 1};
    vt[2] = '{96'h0000_0000_0000_0000_0000_0000, 2, 0,  1'b0, 1'b1, 0};
    vt[3] = '{96'h0201_0000_0000_0000_0000_0000, 2, 0,  1'b0, 1'b1, 0};
    vt[4] = '{96'h0002_1234_ABCD_BE01_0000_0000, 8, 50, 1'b1, 1'b0, 2};
    vt[5] = '{96'h0002_FFFF_0002_0001_0000_0000, 8, 20, 1'b1, 1'b0, 2};
    vt[6] = '{96'h0001_1234_1334_0000_0000_0000, 6, 0,  1'b0, 1'b1, 1};
    vt[7] = '{96'h0001_0000_0000_0000_0000_0000, 6, 30, 1'b1, 1'b0, 1};

    do_reset();
    check_reset_vals("por");

    for (int v = 0; v < 8; v++) begin
      stim_q.delete();
      for (int k = 0; k < vt[v].len; k++) stim_q.push_back(vt[v].bytes[95-8*k -: 8]);
      run_stream(vt[v].idle, 1'b0, 500);
      check($sformatf("vec%0d_done", v), 32'(done), 32'(vt[v].exp_done));
      check($sformatf("vec%0d_error", v), 32'(error), 32'(vt[v].exp_err));
      check($sformatf("vec%0d_nw", v), 32'(wr_q.size()), 32'(vt[v].exp_nw));
    end

    // rx_valid idle for a long stretch mid-session: state must hold
    load_good();
    model_stream();
    wr_q.delete();
    pulse_start();
    send_bytes(0, 2, 0, 1'b0, 100);
    repeat (50) @(negedge clk);
    check("hold_busy", 32'(busy), 1);
    check("hold_rx_ready", 32'(bus.rx_ready), 1);
    send_bytes(2, stim_q.size(), 0, 1'b0, 100);
    wait_idle(100);
    check("hold_done", 32'(done), 1);
    compare_writes();

    // reset after three bytes, then a clean reload from address 0
    load_good();
    wr_q.delete();
    pulse_start();
    send_bytes(0, 3, 0, 1'b0, 100);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_vals("midrst");
    reset = 1'b0;
    check("midrst_nw", 32'(wr_q.size()), 0);
    run_stream(0, 1'b0, 500);

    // reset coincident with the last data byte kills the pending write
    stim_q.delete();
    stim_q = '{8'h00, 8'h01, 8'h00, 8'h07, 8'h00, 8'h07};
    wr_q.delete();
    pulse_start();
    send_bytes(0, 3, 0, 1'b0, 100);
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h07;
    reset = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    check("wrrst_mem_we", 32'(bus.mem_we), 0);
    check_reset_vals("wrrst");
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("wrrst_nw", 32'(wr_q.size()), 0);

    // full depth, value = index, with start pulses sprinkled mid-session
    stim_q.delete();
    stim_q.push_back(8'h02);
    stim_q.push_back(8'h00);
    for (int k = 0; k < DEPTH; k++) begin
      w = 16'(k);
      stim_q.push_back(w[15:8]);
      stim_q.push_back(w[7:0]);
    end
    stim_q.push_back(8'hFF);
    stim_q.push_back(8'h00);
    run_stream(20, 1'b1, 5000);
    check("full_done", 32'(done), 1);
    check("full_nw", 32'(wr_q.size()), 32'(DEPTH));

    // random streams: mostly legal, some bad checksums and bad lengths
    for (int t = 0; t < 25; t++) begin
      stim_q.delete();
      case ($urandom_range(9))
        0:       n = 0;
        1:       n = DEPTH + 1 + int'($urandom_range(300));
        default: n = 1 + int'($urandom_range(9));
      endcase
      w = 16'(n);
      stim_q.push_back(w[15:8]);
      stim_q.push_back(w[7:0]);
      if (n >= 1 && n <= DEPTH) begin
        sum = 0;
        for (int k = 0; k < n; k++) begin
          w = 16'($urandom);
          stim_q.push_back(w[15:8]);
          stim_q.push_back(w[7:0]);
          sum = (sum + int'(w)) % 65536;
        end
        w = 16'(sum);
        if ($urandom_range(3) == 0) w = w ^ (16'($urandom_range(65534)) + 16'd1);
        stim_q.push_back(w[15:8]);
        stim_q.push_back(w[7:0]);
      end
      run_stream(int'($urandom_range(60)), 1'b1, 1000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
